// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: captures operands on a
// multiply request, steps one multiplier bit per cycle and stalls the pipe.
module mul_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  CTRL_MUL = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exValid,
  input  logic [3:0]       aluController,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] mulResult,
  output logic             mulDone
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [5:0]       cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q,   done_d;
  logic             req_s;
  logic [WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0] step_mplier_s;

  assign req_s = exValid && (aluController == CTRL_MUL);

  // Next-state and datapath step; flush overrides every state.
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    done_d        = 1'b0;
    step_acc_s    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    step_mplier_s = mplier_q >> 1;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s) begin
            mcand_d  = srcA;
            mplier_d = srcB;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = 6'd0;
            state_d  = S_BUSY;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_BUSY: begin
          acc_d    = step_acc_s;
          mcand_d  = mcand_q << 1;
          mplier_d = step_mplier_s;
          cnt_d    = cnt_q + 6'd1;
          // The result register loads on the same edge that enters DONE.
          if ((step_mplier_s == {WIDTH{1'b0}}) || (cnt_q == CNT_LAST)) begin
            state_d  = S_DONE;
            result_d = step_acc_s;
            done_d   = 1'b1;
          end else begin
            state_d  = S_BUSY;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the freeze takes effect in the accept cycle.
  always_comb begin
    stall = 1'b0;
    if (rst || flush) begin
      stall = 1'b0;
    end else if (state_q == S_IDLE) begin
      stall = req_s;
    end else if (state_q == S_BUSY) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= 6'd0;
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign mulResult = result_q;
  assign mulDone   = done_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected products,
// a negedge monitor pops them whenever mulDone is seen.
module tb_mul_sequencer;

  localparam logic [3:0] CTRL_MUL = 4'b0010;

  logic        clk;
  logic        rst;
  logic        exValid;
  logic [3:0]  aluController;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        stall;
  logic [31:0] mulResult;
  logic        mulDone;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  mul_sequencer #(.WIDTH(32), .CTRL_MUL(CTRL_MUL)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .aluController(aluController),
    .srcA(srcA), .srcB(srcB), .flush(flush), .stall(stall),
    .mulResult(mulResult), .mulDone(mulDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mulDone must match the oldest outstanding product.
  always @(negedge clk) begin
    if (mulDone === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got mulResult %h, expected no mulDone", mulResult);
      end else begin
        check("mulResult", mulResult, exp_q.pop_front());
      end
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    exValid = 1'b0;
    aluController = 4'b0000;
  endtask

  // Issue a multiply and hold it in EX until stall drops (the DONE cycle).
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int k);
    int cyc;
    int stalls;
    logic last_stall;
    @(posedge clk); #1;
    exValid = 1'b1; aluController = CTRL_MUL; srcA = a; srcB = b;
    exp_q.push_back(exp);
    cyc = 0; stalls = 0; last_stall = 1'b1;
    while (last_stall && cyc < 100) begin
      @(negedge clk);
      cyc++;
      last_stall = (stall === 1'b1);
      if (last_stall) stalls++;
    end
    check("occupancy", 32'(cyc), 32'(k + 2));
    check("stall_cycles", 32'(stalls), 32'(k + 1));
    check("done_on_exit", {31'd0, mulDone}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; exValid = 1'b0; aluController = 4'b0000;
    srcA = 32'd0; srcB = 32'd0; flush = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_result", mulResult, 32'd0);
    check("rst_done", {31'd0, mulDone}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    run_mul(32'd3, 32'd5, 32'd15, 3);
    go_idle();
    run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 2);
    go_idle();
    run_mul(32'd7, 32'd0, 32'd0, 1);
    go_idle();
    run_mul(32'd1, 32'h80000000, 32'h80000000, 32);
    go_idle();
    run_mul(32'h12345678, 32'hFFFFFFFF, 32'hEDCBA988, 32);
    go_idle();
    // Back-to-back: second accept happens in the single IDLE after DONE.
    run_mul(32'd2, 32'd3, 32'd6, 2);
    run_mul(32'd4, 32'd5, 32'd20, 3);
    go_idle();

    // Flush in the second BUSY cycle of 9 * 0xFF.
    @(posedge clk); #1;
    exValid = 1'b1; aluController = CTRL_MUL; srcA = 32'd9; srcB = 32'h000000FF;
    @(negedge clk);
    check("flush_accept_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("flush_busy1_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; flush = 1'b0; exValid = 1'b0; aluController = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_done", {31'd0, mulDone}, 32'd0);
      check("flush_result_held", mulResult, 32'd20);
    end
    run_mul(32'd6, 32'd7, 32'd42, 3);
    go_idle();

    // Non-multiply ops are never stalled.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      exValid = 1'b1; aluController = 4'(c); srcA = 32'd11; srcB = 32'd13;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("nonmul_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
      end
      #1; exValid = 1'b0; aluController = 4'b0000;
    end

    // Reset pulsed mid-BUSY discards the multiply.
    @(posedge clk); #1;
    exValid = 1'b1; aluController = CTRL_MUL; srcA = 32'd9; srcB = 32'h000000FF;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; exValid = 1'b0; aluController = 4'b0000;
    @(negedge clk);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_result", mulResult, 32'd0);
    check("post_rst_done", {31'd0, mulDone}, 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
